ghost_mode_scheduler: RTL and testbench

Sequences the global ghost behaviour modes for the game side of the design. It runs the scatter/chase phase timetable and the frightened timer driven by power pellets. It also tracks per-ghost frightened and eaten status, and produces the 2-bit `*_mode` values consumed by the ghost movement blocks and the graphics block. It runs on the game clock and advances only on the one-cycle frame strobe `tick`.

---
 rtl/ghost_mode_scheduler_if.sv | 28 ++
 rtl/ghost_mode_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_ghost_mode_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ghost_mode_scheduler_if.sv
// Bus bundle between the game logic and ghost_mode_scheduler. It carries the event pulses in
// and the per-ghost mode codes plus the schedule status out.
interface ghost_mode_scheduler_if;
  logic       tick;
  logic       start;
  logic       restart;
  logic       power_pellet;
  logic [3:0] ghost_eaten;
  logic [3:0] ghost_home;
  logic [1:0] blinky_mode;
  logic [1:0] pinky_mode;
  logic [1:0] inky_mode;
  logic [1:0] clyde_mode;
  logic [2:0] phase;
  logic       frightened;
  logic       flash;
  logic       reverse;

  modport master (
    output tick, start, restart, power_pellet, ghost_eaten, ghost_home,
    input  blinky_mode, pinky_mode, inky_mode, clyde_mode, phase, frightened, flash, reverse
  );

  modport slave (
    input  tick, start, restart, power_pellet, ghost_eaten, ghost_home,
    output blinky_mode, pinky_mode, inky_mode, clyde_mode, phase, frightened, flash, reverse
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: scatter/chase timetable, power-pellet fright timer and
// per-ghost frightened/eaten flags, all advancing on the frame strobe and fully registered.
module ghost_mode_scheduler #(
  parameter int SCATTER_LONG  = 420,
  parameter int SCATTER_SHORT = 300,
  parameter int CHASE_TICKS   = 1200,
  parameter int FRIGHT_TICKS  = 360,
  parameter int FLASH_TICKS   = 120,
  parameter int CW            = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  ghost_mode_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCHED  = 2'd1,
    ST_FRIGHT = 2'd2
  } state_e;

  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] FRIGHT_LAST = CW'(FRIGHT_TICKS - 32'sd1);
  localparam logic [CW-1:0] FLASH_START = CW'(FRIGHT_TICKS - FLASH_TICKS);
  localparam logic          FRIGHT_EN   = (FRIGHT_TICKS != 32'sd0);

  function automatic logic [CW-1:0] phase_last(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd2:       phase_last = CW'(SCATTER_LONG - 32'sd1);
      3'd4, 3'd6:       phase_last = CW'(SCATTER_SHORT - 32'sd1);
      3'd1, 3'd3, 3'd5: phase_last = CW'(CHASE_TICKS - 32'sd1);
      default:          phase_last = CNT_MAX;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    fr_q, fr_d;
  logic [3:0]    eat_q, eat_d;
  logic          rev_d;
  logic [7:0]    modes_q, modes_d;
  logic          frightened_q, frightened_d;
  logic          flash_q, flash_d;
  logic          reverse_q;

  // State, counter, flag and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 3'd0;
      pcnt_q       <= '0;
      fcnt_q       <= '0;
      fr_q         <= 4'b0000;
      eat_q        <= 4'b0000;
      modes_q      <= 8'h00;
      frightened_q <= 1'b0;
      flash_q      <= 1'b0;
      reverse_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pcnt_q       <= pcnt_d;
      fcnt_q       <= fcnt_d;
      fr_q         <= fr_d;
      eat_q        <= eat_d;
      modes_q      <= modes_d;
      frightened_q <= frightened_d;
      flash_q      <= flash_d;
      reverse_q    <= rev_d;
    end
  end

  // Next-state logic: restart first, then ghost events, then pellet over tick.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
    fr_d    = fr_q;
    eat_d   = eat_q;
    rev_d   = 1'b0;
    if (bus.restart) begin
      state_d = ST_SCHED;
      phase_d = 3'd0;
      pcnt_d  = '0;
      fcnt_d  = '0;
      fr_d    = 4'b0000;
      eat_d   = 4'b0000;
    end else begin
      // Flags are all clear in IDLE, so these updates are harmless there.
      for (int i = 0; i < 4; i++) begin
        if (bus.ghost_eaten[i] && fr_q[i]) begin
          fr_d[i]  = 1'b0;
          eat_d[i] = 1'b1;
        end else if (bus.ghost_home[i]) begin
          eat_d[i] = 1'b0;
        end else begin
          eat_d[i] = eat_q[i];
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_SCHED;
            phase_d = 3'd0;
            pcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCHED: begin
          if (bus.power_pellet && FRIGHT_EN) begin
            state_d = ST_FRIGHT;
            fcnt_d  = '0;
            fr_d    = ~eat_d;
            rev_d   = 1'b1;
          end else if (bus.tick) begin
            if (phase_q == 3'd7) begin
              pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
            end else if (pcnt_q == phase_last(phase_q)) begin
              phase_d = phase_q + 3'd1;
              pcnt_d  = '0;
              rev_d   = 1'b1;
            end else begin
              pcnt_d = pcnt_q + CNT_ONE;
            end
          end else begin
            pcnt_d = pcnt_q;
          end
        end
        ST_FRIGHT: begin
          if (bus.power_pellet && FRIGHT_EN) begin
            fcnt_d = '0;
            fr_d   = ~eat_d;
          end else if (bus.tick) begin
            if (fcnt_q == FRIGHT_LAST) begin
              state_d = ST_SCHED;
              fcnt_d  = '0;
              fr_d    = 4'b0000;
            end else begin
              fcnt_d = fcnt_q + CNT_ONE;
            end
          end else begin
            fcnt_d = fcnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from next state so every output lands in a register.
  always_comb begin
    modes_d      = 8'h00;
    frightened_d = (state_d == ST_FRIGHT);
    flash_d      = (state_d == ST_FRIGHT) && (fcnt_d >= FLASH_START);
    if (state_d != ST_IDLE) begin
      for (int i = 0; i < 4; i++) begin
        if (eat_d[i]) begin
          modes_d[2*i +: 2] = 2'b11;
        end else if (fr_d[i]) begin
          modes_d[2*i +: 2] = 2'b10;
        end else begin
          modes_d[2*i +: 2] = {1'b0, phase_d[0]};
        end
      end
    end else begin
      modes_d = 8'h00;
    end
  end

  assign bus.blinky_mode = modes_q[1:0];
  assign bus.pinky_mode  = modes_q[3:2];
  assign bus.inky_mode   = modes_q[5:4];
  assign bus.clyde_mode  = modes_q[7:6];
  assign bus.phase       = phase_q;
  assign bus.frightened  = frightened_q;
  assign bus.flash       = flash_q;
  assign bus.reverse     = reverse_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Self-checking bench for ghost_mode_scheduler: vector table, directed multi-cycle scenarios
// and a randomized run compared every cycle against a timetable-based reference model.
module tb_ghost_mode_scheduler;

  localparam int FT = 360;
  localparam int FL = 120;

  logic clk;
  logic rst;
  ghost_mode_scheduler_if gif ();

  ghost_mode_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int rev_cnt = 0;

  // Reference model: elapsed schedule ticks and remaining fright ticks.
  bit       m_on, m_fon, m_rev;
  int       m_t, m_left;
  bit [3:0] m_fr, m_eat;

  function automatic int ph_of(input int t);
    int d [7] = '{420, 1200, 420, 1200, 300, 1200, 300};
    int acc = 0;
    int n = 0;
    for (int k = 0; k < 7; k++) begin
      acc += d[k];
      if (t >= acc) n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_on = 0; m_fon = 0; m_rev = 0; m_t = 0; m_left = 0; m_fr = 0; m_eat = 0;
  endtask

  task automatic model_step(input logic t, s, r, p, input logic [3:0] e, h);
    int old;
    m_rev = 0;
    if (r) begin
      m_on = 1; m_fon = 0; m_t = 0; m_left = 0; m_fr = 0; m_eat = 0;
    end else if (!m_on) begin
      if (s) begin m_on = 1; m_t = 0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (e[i] && m_fr[i]) begin m_fr[i] = 0; m_eat[i] = 1; end
        else if (h[i] && m_eat[i]) m_eat[i] = 0;
      end
      if (p && FT > 0) begin
        if (!m_fon) m_rev = 1;
        m_fon = 1; m_left = FT; m_fr = ~m_eat;
      end else if (t) begin
        if (m_fon) begin
          m_left--;
          if (m_left == 0) begin m_fon = 0; m_fr = 0; end
        end else begin
          old = ph_of(m_t);
          m_t++;
          if (ph_of(m_t) != old) m_rev = 1;
        end
      end
    end
  endtask

  function automatic logic [13:0] model_outs();
    logic [7:0] m = 8'h00;
    int ph = ph_of(m_t);
    if (m_on) begin
      for (int i = 0; i < 4; i++)
        m[2*i +: 2] = m_eat[i] ? 2'b11 : (m_fr[i] ? 2'b10 : ((ph % 2 == 1) ? 2'b01 : 2'b00));
    end
    return {m, 3'(ph), m_fon, (m_fon && m_left <= FL), m_rev};
  endfunction

  function automatic logic [13:0] dut_outs();
    return {gif.clyde_mode, gif.inky_mode, gif.pinky_mode, gif.blinky_mode,
            gif.phase, gif.frightened, gif.flash, gif.reverse};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    gif.tick = 1'b0; gif.start = 1'b0; gif.restart = 1'b0; gif.power_pellet = 1'b0;
    gif.ghost_eaten = 4'b0000; gif.ghost_home = 4'b0000;
  endtask

  // One clock: drive, step the model, sample #1 after the edge and compare.
  task automatic cyc(input logic t, s, r, p, input logic [3:0] e, h);
    gif.tick = t; gif.start = s; gif.restart = r; gif.power_pellet = p;
    gif.ghost_eaten = e; gif.ghost_home = h;
    model_step(t, s, r, p, e, h);
    @(posedge clk);
    #1;
    clear_inputs();
    if (gif.reverse) rev_cnt++;
    chk("model", dut_outs(), model_outs());
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_outs(), 14'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       t, s, r, p;
    logic [3:0] e, h;
    logic [7:0] m;
    logic [2:0] ph;
    logic       fr, fl, rv;
  } vec_t;

  vec_t vt [12];

  initial begin
    rst = 1'b0;
    clear_inputs();
    //          t     s     r     p     eaten    home     modes  ph    fr    fl    rev
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 8'hAA, 3'd0, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 8'hBA, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 8'h8A, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 8'h8B, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'h8B, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 8'hAB, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].t, vt[i].s, vt[i].r, vt[i].p, vt[i].e, vt[i].h);
      chk($sformatf("vec%0d", i), dut_outs(), {vt[i].m, vt[i].ph, vt[i].fr, vt[i].fl, vt[i].rv});
    end

    // First scatter phase and the full timetable.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    rev_cnt = 0;
    run_ticks(419);
    chk("ph0_hold", gif.phase, 3'd0);
    chk("ph0_norev", rev_cnt, 0);
    run_ticks(1);
    chk("ph1_enter", gif.phase, 3'd1);
    chk("ph1_rev", gif.reverse, 1'b1);
    chk("ph1_modes", dut_outs() >> 6, 8'h55);
    rev_cnt = 0;
    run_ticks(4620);
    chk("ph7_reach", gif.phase, 3'd7);
    chk("ph7_revs", rev_cnt, 6);
    rev_cnt = 0;
    run_ticks(5000);
    chk("ph7_stay", gif.phase, 3'd7);
    chk("ph7_norev", rev_cnt, 0);

    // Fright in phase 1 at counter 100, blinky eaten then home.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    chk("restart_ph", gif.phase, 3'd0);
    chk("restart_rev", gif.reverse, 1'b0);
    run_ticks(520);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("fr_modes", dut_outs() >> 6, 8'hAA);
    chk("fr_flag", gif.frightened, 1'b1);
    chk("fr_rev", gif.reverse, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000);
    chk("blinky_eaten", dut_outs() >> 6, 8'hAB);
    rev_cnt = 0;
    run_ticks(239);
    chk("flash_low", gif.flash, 1'b0);
    run_ticks(1);
    chk("flash_high", gif.flash, 1'b1);
    run_ticks(119);
    chk("fr_still", gif.frightened, 1'b1);
    run_ticks(1);
    chk("fr_end", gif.frightened, 1'b0);
    chk("fr_end_modes", dut_outs() >> 6, 8'h57);
    chk("fr_end_norev", rev_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001);
    chk("blinky_home", dut_outs() >> 6, 8'h55);
    run_ticks(1099);
    chk("resume_hold", gif.phase, 3'd1);
    run_ticks(1);
    chk("resume_adv", gif.phase, 3'd2);

    // Pellet on a phase-boundary tick, then re-pellet late in fright.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    run_ticks(419);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("bnd_phase", gif.phase, 3'd0);
    chk("bnd_fr", gif.frightened, 1'b1);
    run_ticks(300);
    chk("bnd_flash", gif.flash, 1'b1);
    rev_cnt = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("repel_flash", gif.flash, 1'b0);
    chk("repel_norev", rev_cnt, 0);
    run_ticks(359);
    chk("repel_fr", gif.frightened, 1'b1);
    run_ticks(1);
    chk("repel_end", gif.frightened, 1'b0);
    run_ticks(1);
    chk("bnd_adv", gif.phase, 3'd1);

    // Asynchronous reset mid-fright, then restart in phase 3.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    run_ticks(10);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst", dut_outs(), 14'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_ticks(3);
    chk("idle_wait", dut_outs(), 14'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    run_ticks(2040);
    chk("ph3", gif.phase, 3'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    chk("ph3_restart", dut_outs(), 14'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 20000; n++) begin
      logic [3:0] e, h;
      for (int b = 0; b < 4; b++) begin
        e[b] = ($urandom % 32) == 0;
        h[b] = ($urandom % 32) == 0;
      end
      cyc(($urandom % 4) != 0, ($urandom % 200) == 0, ($urandom % 5000) == 0,
          ($urandom % 700) == 0, e, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
